// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port synchronous instruction memory between three requesters:
// CPU instruction fetch (IF), CPU data reads from instruction space (D) and the
// bootloader write port (W). One access is granted per cycle. Read data comes
// back from memory one cycle after the grant and is routed to the owner.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   if_req/if_addr            fetch request and word address
//   if_gnt/if_rvalid/if_rdata fetch grant, return valid, data (0 = NOP when not valid)
//   d_req/d_addr              data read request and word address
//   d_gnt/d_rvalid/d_rdata    data read grant, return valid, raw memory data
//   w_req/w_addr/w_data       bootloader write request, address, data
//   w_gnt                     write performed this cycle
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
module imem_port_arbiter #(
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   input  logic              w_req,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_gnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] MaxCnt = 4'(MAX_CONSEC);

   typedef enum logic [1:0] {
      RselNone,
      RselIf,
      RselD
   } rsel_e;

   rsel_e      rsel_q, rsel_d;
   logic [3:0] starve_q, starve_d;
   logic       starved;

   // Grant: W > D > IF, except a fetch that has waited MAX_CONSEC grants wins.
   always_comb begin
      if_gnt  = 1'b0;
      d_gnt   = 1'b0;
      w_gnt   = 1'b0;
      starved = (starve_q == MaxCnt) && if_req;
      if (rst) begin
         if (starved) begin
            if_gnt = 1'b1;
         end else if (w_req) begin
            w_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   // Memory port drive.
   always_comb begin
      mem_en    = if_gnt | d_gnt | w_gnt;
      mem_we    = w_gnt;
      mem_wdata = w_data;
      if (w_gnt) begin
         mem_addr = w_addr;
      end else if (d_gnt) begin
         mem_addr = d_addr;
      end else if (if_gnt) begin
         mem_addr = if_addr;
      end else begin
         mem_addr = '0;
      end
   end

   // Next state: return owner and starvation count.
   always_comb begin
      rsel_d   = RselNone;
      starve_d = starve_q;
      if (if_gnt) begin
         rsel_d = RselIf;
      end else if (d_gnt) begin
         rsel_d = RselD;
      end

      if (!if_req || if_gnt) begin
         starve_d = 4'd0;
      end else if ((w_gnt || d_gnt) && (starve_q != MaxCnt)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rsel_q   <= RselNone;
         starve_q <= 4'd0;
      end else begin
         rsel_q   <= rsel_d;
         starve_q <= starve_d;
      end
   end

   // Returns are suppressed while reset is held so a read granted just before
   // reset never produces an rvalid.
   always_comb begin
      if_rvalid = rst && (rsel_q == RselIf);
      d_rvalid  = rst && (rsel_q == RselD);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = mem_rdata;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req, d_req, w_req;
   logic [ADDR_W-1:0] if_addr, d_addr, w_addr;
   logic [DATA_W-1:0] w_data;
   logic              if_gnt, d_gnt, w_gnt;
   logic              if_rvalid, d_rvalid;
   logic [DATA_W-1:0] if_rdata, d_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   imem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_CONSEC(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_addr   (d_addr),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .w_req    (w_req),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .w_gnt    (w_gnt),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Small synchronous memory model; contents preloaded while reset is held.
   logic [DATA_W-1:0] mem [16];
   always @(posedge clk) begin
      if (!rst) begin
         mem[0] <= 32'h3c0b1f00;
         mem[1] <= 32'h11111111;
         mem[2] <= 32'h22222222;
         mem[3] <= 32'hdeadbeef;
         mem_rdata <= 32'h0;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[3:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [9:0]  starve_pat;
   logic [31:0] stream_exp [4];

   initial begin
      starve_pat    = 10'b10000_10000; // bit i = IF expected in cycle i
      stream_exp[0] = 32'h3c0b1f00;
      stream_exp[1] = 32'h11111111;
      stream_exp[2] = 32'h22222222;
      stream_exp[3] = 32'hdeadbeef;

      // 1. Reset with every request high.
      rst = 1'b0;
      if_req = 1'b1; d_req = 1'b1; w_req = 1'b1;
      if_addr = '0; d_addr = 30'h3; w_addr = 30'h5; w_data = 32'hcafe0000;
      #1;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
         chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
         chk("rst_w_gnt", {31'b0, w_gnt}, 32'd0);
         chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
         chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
         chk("rst_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      end

      // Release reset: IF only at address 0.
      rst = 1'b1; d_req = 1'b0; w_req = 1'b0;
      #1;
      chk("post_rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("post_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("post_rst_if_rdata", if_rdata, 32'd0);
      chk("t1_if_gnt", {31'b0, if_gnt}, 32'd1);
      chk("t1_mem_addr", {2'b0, mem_addr}, 32'd0);
      chk("t1_mem_we", {31'b0, mem_we}, 32'd0);
      tick();
      // 2. Conflict IF vs D in the same cycle the fetch returns.
      if_req = 1'b1; d_req = 1'b1; d_addr = 30'h3;
      #1;
      chk("t1_if_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("t1_if_rdata", if_rdata, 32'h3c0b1f00);
      chk("t2_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("t2_if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("t2_mem_addr", {2'b0, mem_addr}, 32'h3);
      tick();
      d_req = 1'b0;
      #1;
      chk("t2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
      chk("t2_d_rdata", d_rdata, 32'hdeadbeef);
      chk("t2_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("t2_if_rdata_nop", if_rdata, 32'd0);
      chk("t2_if_gnt_next", {31'b0, if_gnt}, 32'd1);
      tick();

      // 3. Starvation: W and IF held for 10 cycles.
      w_req = 1'b1; if_req = 1'b1; if_addr = 30'h1;
      for (int c = 0; c < 10; c++) begin
         w_data = 32'hab000000 + c;
         #1;
         chk($sformatf("t3_if_gnt_%0d", c), {31'b0, if_gnt}, {31'b0, starve_pat[c]});
         chk($sformatf("t3_w_gnt_%0d", c), {31'b0, w_gnt}, {31'b0, ~starve_pat[c]});
         chk($sformatf("t3_mem_we_%0d", c), {31'b0, mem_we}, {31'b0, ~starve_pat[c]});
         tick();
      end
      w_req = 1'b0; if_req = 1'b0;
      #1;
      chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
      chk("idle_mem_addr", {2'b0, mem_addr}, 32'd0);
      tick();

      // 4. Streaming fetch of addresses 0..3.
      for (int k = 0; k < 4; k++) begin
         if_req = 1'b1; if_addr = 30'(k);
         #1;
         chk($sformatf("t4_if_gnt_%0d", k), {31'b0, if_gnt}, 32'd1);
         if (k == 0) begin
            chk("t4_rvalid_before", {31'b0, if_rvalid}, 32'd0);
         end else begin
            chk($sformatf("t4_rvalid_%0d", k), {31'b0, if_rvalid}, 32'd1);
            chk($sformatf("t4_rdata_%0d", k), if_rdata, stream_exp[k-1]);
         end
         tick();
      end
      if_req = 1'b0;
      #1;
      chk("t4_rvalid_3", {31'b0, if_rvalid}, 32'd1);
      chk("t4_rdata_3", if_rdata, stream_exp[3]);
      tick();
      chk("t4_rvalid_after", {31'b0, if_rvalid}, 32'd0);

      // 5. Reset while a D read is in flight.
      d_req = 1'b1; d_addr = 30'h2;
      #1;
      chk("t5_d_gnt", {31'b0, d_gnt}, 32'd1);
      tick();
      rst = 1'b0; d_req = 1'b0;
      #1;
      chk("t5_d_rvalid_rst", {31'b0, d_rvalid}, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("t5_d_rvalid_after", {31'b0, d_rvalid}, 32'd0);
      chk("t5_if_rdata_after", if_rdata, 32'd0);

      // 6. W stream with no fetch pending keeps the counter at 0.
      w_req = 1'b1; w_addr = 30'h6;
      for (int c = 0; c < 6; c++) begin
         w_data = 32'h60000000 + c;
         #1;
         chk($sformatf("t6_w_gnt_%0d", c), {31'b0, w_gnt}, 32'd1);
         tick();
         chk($sformatf("t6_cnt_%0d", c), {28'b0, dut.starve_q}, 32'd0);
      end
      if_req = 1'b1; if_addr = 30'h2;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t6_if_gnt_%0d", c), {31'b0, if_gnt}, (c == 4) ? 32'd1 : 32'd0);
         tick();
      end
      w_req = 1'b0; if_req = 1'b0;
      #1;
      chk("t6_if_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("t6_if_rdata", if_rdata, 32'h22222222);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
